// File: rtl/echo_wb_trace_if.sv
// Bundle for the echo_wb_trace block: the core's debug write-back port on
// one side and the drained trace stream plus status on the other.
// The core/consumer side uses the master modport; the trace buffer uses slave.
interface echo_wb_trace_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    // Core write-back port
    logic                debug_write_enabled;
    logic [4:0]          debug_write_addr;
    logic [XLEN-1:0]     debug_write_data;

    // Trace stream
    logic                trace_valid;
    logic                trace_ready;
    logic [4:0]          trace_addr;
    logic [XLEN-1:0]     trace_data;
    logic [SEQ_W-1:0]    trace_seq;

    // Status
    logic [LVL_W-1:0]    trace_level;
    logic                overflow;
    logic [15:0]         drop_count;

    modport master (
        output debug_write_enabled, debug_write_addr, debug_write_data,
        output trace_ready,
        input  trace_valid, trace_addr, trace_data, trace_seq,
        input  trace_level, overflow, drop_count
    );

    modport slave (
        input  debug_write_enabled, debug_write_addr, debug_write_data,
        input  trace_ready,
        output trace_valid, trace_addr, trace_data, trace_seq,
        output trace_level, overflow, drop_count
    );
endinterface

// File: rtl/echo_wb_trace.sv
// Write-back trace buffer. Captures every retired register write from the
// core, tags it with a running sequence number and queues it in a FIFO that a
// consumer drains over a ready/valid stream. Events that arrive while the
// FIFO is full (and nothing leaves that cycle) are dropped, counted and
// flagged through a sticky overflow bit; they still consume a sequence number
// so the consumer sees the loss as a gap in trace_seq.
module echo_wb_trace #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int SEQ_W     = 16,
    parameter int FILTER_X0 = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    echo_wb_trace_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0]       addr;
        logic [XLEN-1:0]  data;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] level;
    logic [SEQ_W-1:0] seq_cnt;
    logic             overflow;
    logic [15:0]      drop_count;

    logic             is_x0;
    logic             is_event;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // Event qualification and FIFO handshakes. A pop frees a slot in the same
    // cycle, so a full FIFO still accepts an event when the consumer is ready.
    assign is_x0    = (FILTER_X0 != 0) && (bus.debug_write_addr == 5'd0);
    assign is_event = run && bus.debug_write_enabled && !is_x0;
    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(DEPTH));
    assign pop      = !empty && bus.trace_ready;
    assign push     = is_event && (!full || pop);
    assign drop     = is_event && !push;

    // Pointers, occupancy, sequence counter and drop accounting.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            seq_cnt    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);

            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            if (is_event) seq_cnt <= seq_cnt + SEQ_W'(1);

            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Entry storage; written on every accepted event.
    // NOTE: the storage array is deliberately not reset -- occupancy and
    // pointers define which entries are live, and the head fields are masked
    // while empty, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr] <= '{addr: bus.debug_write_addr,
                             data: bus.debug_write_data,
                             seq:  seq_cnt};
        end
    end

    // Head fields come straight from the read pointer; zero while empty so
    // reset and drained states present a clean all-zero head.
    assign head            = mem[rd_ptr];
    assign bus.trace_valid = !empty;
    assign bus.trace_addr  = empty ? '0 : head.addr;
    assign bus.trace_data  = empty ? '0 : head.data;
    assign bus.trace_seq   = empty ? '0 : head.seq;
    assign bus.trace_level = level;
    assign bus.overflow    = overflow;
    assign bus.drop_count  = drop_count;
endmodule

// File: tb/tb_echo_wb_trace.sv
// Self-checking bench for echo_wb_trace. Two instances share the write-back
// stimulus: "a" uses the default configuration, "b" has a 4-deep FIFO, a
// 4-bit sequence number and no x0 filter. Each is followed by a queue-based
// reference model compared after every clock edge, and directed tables and
// sequences add hand-computed expectations for the corner cases.
module tb_echo_wb_trace;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        we  = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] data = '0;
    logic        ready = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    echo_wb_trace_if #(.XLEN(XLEN), .DEPTH(16), .SEQ_W(16)) if_a ();
    echo_wb_trace_if #(.XLEN(XLEN), .DEPTH(4),  .SEQ_W(4))  if_b ();

    assign if_a.debug_write_enabled = we;
    assign if_a.debug_write_addr    = addr;
    assign if_a.debug_write_data    = data;
    assign if_a.trace_ready         = ready;
    assign if_b.debug_write_enabled = we;
    assign if_b.debug_write_addr    = addr;
    assign if_b.debug_write_data    = data;
    assign if_b.trace_ready         = ready;

    echo_wb_trace #(.XLEN(XLEN), .DEPTH(16), .SEQ_W(16), .FILTER_X0(1)) dut_a (
        .clk(clk), .rst(rst), .run(run), .bus(if_a.slave)
    );
    echo_wb_trace #(.XLEN(XLEN), .DEPTH(4), .SEQ_W(4), .FILTER_X0(0)) dut_b (
        .clk(clk), .rst(rst), .run(run), .bus(if_b.slave)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          seq;
    } ent_t;

    ent_t mq [2][$];
    int   mseq  [2];
    bit   mov   [2];
    int   mdrop [2];

    function automatic int m_depth(int k);  return (k == 0) ? 16 : 4;     endfunction
    function automatic int m_mod(int k);    return (k == 0) ? 65536 : 16; endfunction
    function automatic bit m_filter(int k); return (k == 0);              endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                mq[k].delete();
                mseq[k]  = 0;
                mov[k]   = 0;
                mdrop[k] = 0;
            end else begin
                bit   do_pop;
                bit   ev;
                ent_t e;
                do_pop = (mq[k].size() > 0) && ready;
                ev     = run && we && !(m_filter(k) && addr == 5'd0);
                if (do_pop) void'(mq[k].pop_front());
                if (ev) begin
                    if (mq[k].size() < m_depth(k)) begin
                        e.addr = addr;
                        e.data = data;
                        e.seq  = mseq[k];
                        mq[k].push_back(e);
                    end else begin
                        mov[k] = 1;
                        if (mdrop[k] < 65535) mdrop[k]++;
                    end
                    mseq[k] = (mseq[k] + 1) % m_mod(k);
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic cmp_model(input int k, input string tag,
                             input logic v, input int lvl, input logic ov,
                             input logic [15:0] dc, input logic [4:0] a,
                             input logic [31:0] d, input int s);
        logic [4:0]  ea = '0;
        logic [31:0] ed = '0;
        int          es = 0;
        if (mq[k].size() > 0) begin
            ea = mq[k][0].addr;
            ed = mq[k][0].data;
            es = mq[k][0].seq;
        end
        check({tag, ".valid"},      64'(v),   64'(mq[k].size() != 0));
        check({tag, ".level"},      64'(lvl), 64'(mq[k].size()));
        check({tag, ".overflow"},   64'(ov),  64'(mov[k]));
        check({tag, ".drop_count"}, 64'(dc),  64'(mdrop[k]));
        check({tag, ".head_addr"},  64'(a),   64'(ea));
        check({tag, ".head_data"},  64'(d),   64'(ed));
        check({tag, ".head_seq"},   64'(s),   64'(es));
    endtask

    // One clock: advance the model with the inputs the DUT sampled, then
    // compare both instances shortly after the edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        cmp_model(0, "a", if_a.trace_valid, int'(if_a.trace_level), if_a.overflow,
                  if_a.drop_count, if_a.trace_addr, if_a.trace_data, int'(if_a.trace_seq));
        cmp_model(1, "b", if_b.trace_valid, int'(if_b.trace_level), if_b.overflow,
                  if_b.drop_count, if_b.trace_addr, if_b.trace_data, int'(if_b.trace_seq));
    endtask

    task automatic set_in(input logic r, input logic w, input logic [4:0] ad,
                          input logic [31:0] dt, input logic rd);
        run   = r;
        we    = w;
        addr  = ad;
        data  = dt;
        ready = rd;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        repeat (n) cycle();
        rst = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        ready;
        int          lvl;
        logic [4:0]  ea;
        logic [31:0] ed;
        int          es;
        int          lvl_b;
    } vec_t;

    vec_t vt [13];

    initial begin
        // reset, then three back-to-back events with the consumer ready
        vt[0]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 0, 5'd0, 32'h0,  0, 0};
        vt[1]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 0, 5'd0, 32'h0,  0, 0};
        vt[2]  = '{1'b1, 1'b1, 5'd5, 32'h11,   1'b1, 1, 5'd5, 32'h11, 0, 1};
        vt[3]  = '{1'b1, 1'b1, 5'd6, 32'h22,   1'b1, 1, 5'd6, 32'h22, 1, 1};
        vt[4]  = '{1'b1, 1'b1, 5'd7, 32'h33,   1'b1, 1, 5'd7, 32'h33, 2, 1};
        vt[5]  = '{1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 0, 5'd0, 32'h0,  0, 0};
        // x0 write between two x1 writes: filtered in a, kept in b
        vt[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 0, 5'd0, 32'h0,  0, 0};
        vt[7]  = '{1'b1, 1'b1, 5'd1, 32'hA1,   1'b0, 1, 5'd1, 32'hA1, 0, 1};
        vt[8]  = '{1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b0, 1, 5'd1, 32'hA1, 0, 2};
        vt[9]  = '{1'b1, 1'b1, 5'd1, 32'hA2,   1'b0, 2, 5'd1, 32'hA1, 0, 3};
        vt[10] = '{1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 1, 5'd1, 32'hA2, 1, 2};
        vt[11] = '{1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 0, 5'd0, 32'h0,  0, 1};
        vt[12] = '{1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 0, 5'd0, 32'h0,  0, 0};
    end

    // ---------------- test sequence ----------------
    initial begin
        int thr;
        #1;

        // Table: reset state, basic latency, x0 filter
        for (int i = 0; i < 13; i++) begin
            rst = vt[i].rst;
            set_in(1'b1, vt[i].we, vt[i].addr, vt[i].data, vt[i].ready);
            cycle();
            check($sformatf("tbl%0d.valid", i), 64'(if_a.trace_valid), 64'(vt[i].lvl != 0));
            check($sformatf("tbl%0d.level", i), 64'(if_a.trace_level), 64'(vt[i].lvl));
            check($sformatf("tbl%0d.addr", i),  64'(if_a.trace_addr),  64'(vt[i].ea));
            check($sformatf("tbl%0d.data", i),  64'(if_a.trace_data),  64'(vt[i].ed));
            check($sformatf("tbl%0d.seq", i),   64'(if_a.trace_seq),   64'(vt[i].es));
            check($sformatf("tbl%0d.ovf", i),   64'(if_a.overflow),    64'(0));
            check($sformatf("tbl%0d.level_b", i), 64'(if_b.trace_level), 64'(vt[i].lvl_b));
        end
        rst = 1'b1;

        // Overflow: 20 stalled events into 16 slots, then drain
        do_reset(1);
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 1'b1, 5'((i % 31) + 1), 32'hC000_0000 + 32'(i), 1'b0);
            cycle();
        end
        set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle();
        check("ovf.level",      64'(if_a.trace_level), 64'(16));
        check("ovf.overflow",   64'(if_a.overflow),    64'(1));
        check("ovf.drop_count", 64'(if_a.drop_count),  64'(4));
        check("ovf.drop_b",     64'(if_b.drop_count),  64'(16));
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain.seq%0d", i), 64'(if_a.trace_seq), 64'(i));
            set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
            cycle();
        end
        check("drain.empty", 64'(if_a.trace_valid), 64'(0));
        set_in(1'b1, 1'b1, 5'd3, 32'h3333, 1'b0);
        cycle();
        check("after_drop.seq",   64'(if_a.trace_seq),  64'(20));
        check("after_drop.sticky", 64'(if_a.overflow),  64'(1));

        // Full FIFO with a simultaneous pop and push: no drop
        do_reset(1);
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, 1'b1, 5'd2, 32'h100 + 32'(i), 1'b0);
            cycle();
        end
        check("full.level", 64'(if_a.trace_level), 64'(16));
        set_in(1'b1, 1'b1, 5'd9, 32'hBEEF, 1'b1);
        cycle();
        check("fullpp.level", 64'(if_a.trace_level), 64'(16));
        check("fullpp.drops", 64'(if_a.drop_count),  64'(0));
        check("fullpp.ovf",   64'(if_a.overflow),    64'(0));
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fullpp.seq%0d", i), 64'(if_a.trace_seq), 64'(i + 1));
            if (i == 15) begin
                check("fullpp.last_data", 64'(if_a.trace_data), 64'(32'hBEEF));
                check("fullpp.last_addr", 64'(if_a.trace_addr), 64'(9));
            end
            set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
            cycle();
        end

        // Reset mid-stream with 8 stalled entries (b has overflowed)
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'b1, 5'd4, 32'h200 + 32'(i), 1'b0);
            cycle();
        end
        check("mid.level",  64'(if_a.trace_level), 64'(8));
        check("mid.ovf_b",  64'(if_b.overflow),    64'(1));
        rst = 1'b0;
        set_in(1'b1, 1'b1, 5'd4, 32'h2FF, 1'b1);
        cycle();
        rst = 1'b1;
        check("mid.valid",  64'(if_a.trace_valid), 64'(0));
        check("mid.level0", 64'(if_a.trace_level), 64'(0));
        check("mid.ovf",    64'(if_a.overflow),    64'(0));
        check("mid.ovf_b0", 64'(if_b.overflow),    64'(0));
        set_in(1'b1, 1'b1, 5'd8, 32'h808, 1'b0);
        cycle();
        check("mid.seq_a", 64'(if_a.trace_seq), 64'(0));
        check("mid.seq_b", 64'(if_b.trace_seq), 64'(0));

        // Random run: consumer throughput varies in phases, rare resets
        thr = 50;
        for (int i = 0; i < 10000; i++) begin
            if (i % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0:       thr = 15;
                    1:       thr = 50;
                    default: thr = 90;
                endcase
            end
            rst   = ($urandom_range(0, 1999) != 0);
            run   = ($urandom_range(0, 9) != 0);
            we    = ($urandom_range(0, 3) != 0);
            addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            data  = $urandom;
            ready = ($urandom_range(0, 99) < thr);
            cycle();
        end
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
